// File: rtl/iterative_divider_pkg.sv
// Shared width defaults and FSM encoding for the iterative 64-bit divider.
package iterative_divider_pkg;

  localparam int WORD_DEF  = 64;
  localparam int CNT_W_DEF = $clog2(WORD_DEF) + 1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIN  = 2'd2
  } div_state_e;

endpackage

// File: rtl/iterative_divider_step.sv
// One restoring shift-compare-subtract step of the magnitude divider (combinational).
module iterative_divider_step
  import iterative_divider_pkg::*;
#(
  parameter int WORD = WORD_DEF
) (
  input  logic [WORD-1:0] rem_i,
  input  logic [WORD-1:0] quo_i,
  input  logic [WORD-1:0] dmag_i,
  output logic [WORD-1:0] rem_o,
  output logic [WORD-1:0] quo_o
);

  logic [WORD:0]   sh;
  logic [WORD+1:0] sum;
  logic            ge;
  logic            unused_sum_msb;

  // Shifted remainder is WORD+1 bits; the adder's carry-out is the "no borrow" flag.
  assign sh  = {rem_i, quo_i[WORD-1]};
  assign sum = {1'b0, sh} + {1'b0, ~{1'b0, dmag_i}} + (WORD+2)'(1);
  assign ge  = sum[WORD+1];

  // The restored remainder is always < dmag, so it fits back in WORD bits.
  assign unused_sum_msb = sum[WORD];
  assign rem_o = ge ? sum[WORD-1:0] : sh[WORD-1:0];
  assign quo_o = {quo_i[WORD-2:0], ge};

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle UDIV/SDIV unit: one shift-subtract step per clock, start/busy/done handshake.
module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int WORD  = WORD_DEF,
  parameter int CNT_W = $clog2(WORD) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            signed_op,
  input  logic [WORD-1:0] dividend,
  input  logic [WORD-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [WORD-1:0] quotient,
  output logic [WORD-1:0] remainder,
  output logic            div_by_zero
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WORD-1:0]  rem_q, rem_d, quo_q, quo_d, dmag_q, dmag_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [WORD-1:0]  quot_q, quot_d, remo_q, remo_d;
  logic             dbz_q, dbz_d;
  logic [WORD-1:0]  step_rem, step_quo, a_mag, b_mag;
  logic             accept;

  iterative_divider_step #(.WORD(WORD)) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dmag_i (dmag_q),
    .rem_o  (step_rem),
    .quo_o  (step_quo)
  );

  assign accept = start && (state_q != DIV_RUN);
  assign a_mag  = (signed_op && dividend[WORD-1]) ? -dividend : dividend;
  assign b_mag  = (signed_op && divisor[WORD-1])  ? -divisor  : divisor;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dmag_d  = dmag_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    case (state_q)
      DIV_RUN: begin
        if (dz_q) begin
          // quo_q still holds |dividend|; re-applying r_neg restores the raw dividend.
          state_d = DIV_FIN;
          quot_d  = '0;
          remo_d  = rneg_q ? -quo_q : quo_q;
          dbz_d   = 1'b1;
        end else if (cnt_q == CNT_W'(WORD)) begin
          state_d = DIV_FIN;
          quot_d  = qneg_q ? -quo_q : quo_q;
          remo_d  = rneg_q ? -rem_q : rem_q;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DIV_FIN:  state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (accept) begin
      state_d = DIV_RUN;
      cnt_d   = '0;
      rem_d   = '0;
      quo_d   = a_mag;
      dmag_d  = b_mag;
      qneg_d  = signed_op && (dividend[WORD-1] ^ divisor[WORD-1]);
      rneg_d  = signed_op && dividend[WORD-1];
      dz_d    = (divisor == '0);
      dbz_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dmag_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dmag_q  <= dmag_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == DIV_RUN);
  assign done        = (state_q == DIV_FIN);
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Scoreboard bench for iterative_divider: driver pushes expected results, monitor checks on done.
module tb_iterative_divider;

  localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start, signed_op;
  logic [63:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [63:0] quotient, remainder;

  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  exp_t sb[$];

  iterative_divider dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: ARMv8 UDIV/SDIV semantics with plain integer arithmetic.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic s);
    exp_t   e;
    longint sa, sbv;
    e.due = 0;
    e.dz  = 1'b0;
    if (b == 64'd0) begin
      e.q = 64'd0; e.r = a; e.dz = 1'b1;
    end else if (!s) begin
      e.q = a / b; e.r = a % b;
    end else if (a == INT_MIN && b == ONES) begin
      e.q = INT_MIN; e.r = 64'd0;
    end else begin
      sa = a; sbv = b;
      e.q = sa / sbv; e.r = sa % sbv;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dz});
        chk("done_cycle", 64'(cyc), 64'(e.due));
        chk("busy_at_done", {63'd0, busy}, 64'd0);
      end
    end
  end

  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic s, output int k);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("wait_idle_timeout", 64'd1, 64'd0);
    start = 1'b1; dividend = a; divisor = b; signed_op = s;
    e = model(a, b, s);
    @(posedge clk); #1;
    k = cyc;
    e.due = k + ((b == 64'd0) ? 1 : 65);
    sb.push_back(e);
    start = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = {$urandom, $urandom};
    signed_op = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  logic [63:0] ra, rb;
  int k;

  initial begin
    reset = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_quotient", quotient, 64'd0);
    chk("rst_remainder", remainder, 64'd0);
    chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    reset = 1'b0;

    do_op(64'd100, 64'd7, 1'b0, k);
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    drain();
    do_op(-64'sd100, 64'd7, 1'b1, k);
    do_op(64'd100, -64'sd7, 1'b1, k);
    do_op(INT_MIN, ONES, 1'b1, k);
    do_op(ONES, 64'd0, 1'b0, k);
    // Back-to-back off the divide-by-zero FIN: flag clears on accept, results hold.
    do_op(64'd50, 64'd5, 1'b0, k);
    chk("dbz_cleared_on_accept", {63'd0, div_by_zero}, 64'd0);
    chk("rem_held_after_accept", remainder, ONES);
    chk("quo_held_after_accept", quotient, 64'd0);
    drain();

    // start pulse mid-RUN must be ignored
    do_op(64'd1000, 64'd10, 1'b0, k);
    repeat (10) @(negedge clk);
    start = 1'b1; dividend = 64'd77; divisor = 64'd0; signed_op = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_ignored_start", {63'd0, busy}, 64'd1);
    drain();
    repeat (5) @(negedge clk);

    // Reset mid-RUN, with start asserted in the same edge: abort, nothing accepted.
    do_op(64'd12345, 64'd7, 1'b0, k);
    repeat (30) @(negedge clk);
    reset = 1'b1; start = 1'b1; dividend = 64'd5; divisor = 64'd1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    sb.delete();
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_quotient", quotient, 64'd0);
    chk("abort_remainder", remainder, 64'd0);
    chk("abort_dbz", {63'd0, div_by_zero}, 64'd0);
    repeat (80) @(negedge clk);
    do_op(64'd9, 64'd3, 1'b0, k);
    drain();

    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: rb = 64'd0;
        1: rb = 64'($urandom_range(1, 20));
        2: rb = -64'($urandom_range(1, 20));
        3: rb = {32'd0, $urandom};
        default: rb = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 7) == 0) ra = INT_MIN;
      do_op(ra, rb, 1'($urandom), k);
      repeat ($urandom_range(0, 2) * 66) @(negedge clk);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
